seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
Time-multiplexed driver for a bank of common-anode 7-segment digits: one shared active-low segment bus, one active-low anode per digit. It generalises the single-digit BCD decoder to DIGITS digits with hex/BCD mode, leading-zero blanking, per-digit decimal points and per-digit blink. Display values are double-buffered and change only at frame boundaries, so a frame never tears. It sits between the core's debug/status registers and the board display pins.

Parameters:
DIGITS, 8, number of digits scanned; legal range 2..16
SCAN_DIV, 1000, clk cycles each digit is held; must be >= 2
BLINK_FRAMES, 64, frames per blink half-period; must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
load  in  1  one-cycle strobe that captures value, dp_in and blink_mask
value  in  4*DIGITS  nibble i drives digit i; digit 0 is least significant and rightmost
dp_in  in  DIGITS  1 = decimal point lit on digit i
blink_mask  in  DIGITS  1 = digit i blinks
hex_mode  in  1  1 = nibbles 10..15 shown as A b C d E F; 0 = BCD, 10..15 blank
lz_blank  in  1  1 = blank leading zeros
enable  in  1  0 = display dark, counters frozen
seg  out  7  active-low segments, {g,f,e,d,c,b,a}, so seg[0] = a
dp  out  1  active-low decimal point
an  out  DIGITS  active-low anode selects, at most one bit low
frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset, asynchronous: seg=7'h7F, dp=1, an=all 1, frame_tick=0. The divider, scan index, blink counter and blink phase reset to 0. The pending and active buffers reset to 0.
- Divider: div counts 0..SCAN_DIV-1 while enable=1. At the terminal count, div returns to 0 and idx advances. idx wraps from DIGITS-1 to 0. idx width is clog2(DIGITS).
- Frame boundary: the cycle in which idx wraps from DIGITS-1 to 0. On this cycle:
  - the pending buffer is copied into the active buffer;
  - frame_tick is pulsed for 1 cycle, registered, so it is visible on the following cycle;
  - the blink counter increments; at BLINK_FRAMES-1 it returns to 0 and the blink phase toggles.
- load: captures value, dp_in and blink_mask into the pending buffer. If several loads occur within one frame, the last one wins.
  - If load coincides with a frame boundary, the loaded data goes straight to the active buffer.
  - hex_mode and lz_blank are not buffered; they take effect immediately.
- Outputs are registered and reflect the idx value of the previous cycle, so latency from an idx change to the pins is 1 clk. In steady state, an has exactly bit idx low.
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - A nibble of 10..15 with hex_mode=0 decodes to blank (1111111).
- Leading-zero blanking: when lz_blank=1, digit i is blanked if every active nibble from i up to DIGITS-1 is 0. Digit 0 is never blanked by this rule, so value 0 shows as a single "0". The digit's dp still follows dp_in.
- Blink: when the blink phase is 1 and blink_mask[i]=1, digit i shows seg=7F and dp=1, but its anode still scans.
- dp = ~active_dp[idx] unless the digit is blinked off.
- enable=0: an=all 1, seg=7F, dp=1 from the next cycle. div, idx and the blink state hold. load still updates pending, and pending copies to active immediately because no frame boundary can occur while disabled. Re-enabling resumes from the held idx.
- Reset asserted mid-frame: all state clears asynchronously. After release, the scan restarts at digit 0 with div=0.

Test Plan:
Each scenario uses DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, enable=1 and hex_mode=1 unless stated otherwise.

1. Reset then load value=16'h12AF, lz_blank=0.
   - Before the first frame boundary, every digit shows seg=1000000 ("0").
   - After the frame boundary, the digits show an=1110/seg=0001110, an=1101/0001000, an=1011/0100100, an=0111/1111001.
   - Each anode is held for 4 cycles, and frame_tick pulses every 16 cycles.
2. hex_mode=0, value=16'h9A05.
   - Digit 0 shows 0010010, digit 1 shows 1000000, digit 2 is blank 1111111, digit 3 shows 0010000.
3. lz_blank=1, value=16'h0030.
   - Digits 3 and 2 show 1111111, digit 1 shows 0110000, digit 0 shows 1000000.
   - value=0 shows only digit 0 as 1000000.
4. blink_mask=4'b0001, dp_in=4'b0001.
   - Digit 0 shows seg and dp lit during frames 0-1, then blank with dp=1 during frames 2-3, and so on.
   - The other digits never blink.
5. load at cycle 5 (mid-frame) with value=16'h1111, then load 16'h2222 at cycle 9.
   - The current frame shows the old data.
   - The next frame shows only 2222.
6. Assert rst_n=0 while idx=2, mid-divider.
   - In the same cycle: an=1111, seg=1111111, dp=1.
   - After release, the first anode driven is an=1110, with the active buffer at 0.
   - With enable=0, an stays 1111 and frame_tick stays 0.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: buffered display data and controls
// in, scanned segment/anode pins out.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blink_mask;
  logic                  hex_mode;
  logic                  lz_blank;
  logic                  enable;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_tick;

  modport master (
    output load, value, dp_in, blink_mask, hex_mode, lz_blank, enable,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  load, value, dp_in, blink_mask, hex_mode, lz_blank, enable,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered data,
// hex/BCD decode, leading-zero blanking, per-digit decimal point and blink.
module seg7_scan_lane (
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  input  logic       i_blink_off,
  input  logic       i_lead_zero,
  input  logic       i_hex_mode,
  output logic [6:0] o_seg,
  output logic       o_dp
);
  always_comb begin
    o_seg = 7'h7F;
    o_dp  = ~i_dp;
    case (i_nib)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      default: o_seg = 7'b0001110;
    endcase
    if ((!i_hex_mode && i_nib > 4'd9) || i_lead_zero) o_seg = 7'h7F;
    // Blink-off darkens the whole digit, dp included; the anode keeps scanning.
    if (i_blink_off) begin
      o_seg = 7'h7F;
      o_dp  = 1'b1;
    end
  end
endmodule

module seg7_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input logic              clk,
  input logic              rst_n,
  seg7_scan_driver_if.slave bus
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DW-1:0]              r_div;
  logic [IW-1:0]              r_idx;
  logic [BW-1:0]              r_blk_cnt;
  logic                       r_blk_phase;
  logic [DIGITS-1:0][3:0]     r_pend_val, r_act_val;
  logic [DIGITS-1:0]          r_pend_dp, r_act_dp, r_pend_blk, r_act_blk;
  logic [6:0]                 r_seg;
  logic                       r_dp;
  logic [DIGITS-1:0]          r_an;
  logic                       r_frame_tick;

  logic                       w_tc, w_frame, w_upd;
  logic [DIGITS-1:0][3:0]     w_src_val;
  logic [DIGITS-1:0]          w_src_dp, w_src_blk, w_lz, w_dp;
  logic [DIGITS-1:0][6:0]     w_seg;

  assign w_tc    = bus.enable && (r_div == DW'(SCAN_DIV - 1));
  assign w_frame = w_tc && (r_idx == IW'(DIGITS - 1));
  // While disabled no boundary can come, so the active copy tracks pending.
  assign w_upd   = w_frame || !bus.enable;

  assign w_src_val = bus.load ? bus.value      : r_pend_val;
  assign w_src_dp  = bus.load ? bus.dp_in      : r_pend_dp;
  assign w_src_blk = bus.load ? bus.blink_mask : r_pend_blk;

  for (genvar i = 0; i < DIGITS; i++) begin : g_lane
    if (i == 0) begin : g_lsd
      assign w_lz[i] = 1'b0;
    end else begin : g_upper
      assign w_lz[i] = bus.lz_blank && (r_act_val[DIGITS-1:i] == '0);
    end
    seg7_scan_lane u_lane (
      .i_nib       (r_act_val[i]),
      .i_dp        (r_act_dp[i]),
      .i_blink_off (r_blk_phase && r_act_blk[i]),
      .i_lead_zero (w_lz[i]),
      .i_hex_mode  (bus.hex_mode),
      .o_seg       (w_seg[i]),
      .o_dp        (w_dp[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div        <= '0;
      r_idx        <= '0;
      r_blk_cnt    <= '0;
      r_blk_phase  <= 1'b0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_blk   <= '0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_act_blk    <= '0;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      if (bus.enable) begin
        r_div <= w_tc ? '0 : r_div + 1'b1;
        if (w_tc) r_idx <= w_frame ? '0 : r_idx + 1'b1;
      end
      if (bus.load) begin
        r_pend_val <= bus.value;
        r_pend_dp  <= bus.dp_in;
        r_pend_blk <= bus.blink_mask;
      end
      if (w_upd) begin
        r_act_val <= w_src_val;
        r_act_dp  <= w_src_dp;
        r_act_blk <= w_src_blk;
      end
      if (w_frame) begin
        if (r_blk_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blk_cnt   <= '0;
          r_blk_phase <= ~r_blk_phase;
        end else begin
          r_blk_cnt <= r_blk_cnt + 1'b1;
        end
      end
      r_frame_tick <= w_frame;
      if (bus.enable) begin
        r_an  <= ~({{(DIGITS-1){1'b0}}, 1'b1} << r_idx);
        r_seg <= w_seg[r_idx];
        r_dp  <= w_dp[r_idx];
      end else begin
        r_an  <= '1;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_frame_tick;
endmodule
